// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Drives the stall enables and active-low flushes of the fetch/decode and
//   decode/execute pipeline registers. It handles three kinds of events:
//   load-use hazards, taken branch/jump redirects resolved in execute, and
//   waits for I-cache and D-cache refills. It also keeps a saturating count
//   of decode-stall cycles and a sticky flag that reports a refill timeout.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   Rs1_d, Rs2_d, Rs1_used_d,
//   Rs2_used_d                      decode-stage source operands
//   Rd_e, RegWrite_e, ResultSrc_e   execute-stage destination and result select
//   PCSrc_e                         taken branch/jump resolved in execute
//   imiss, iready                   icache miss / refill done
//   dmiss, dready                   dcache miss / refill done
//   en_f, en_d, en_m                register enables (active high)
//   flush_n_d, flush_n_e            register clears (active low)
//   timeout_err                     sticky refill-timeout flag
//   stall_count                     saturating count of cycles with en_d == 0
module hazard_ctrl #(
   parameter int                    REG_ADDR_WIDTH = 5,
   parameter int                    SRC_WIDTH      = 2,
   parameter logic [SRC_WIDTH-1:0]  LOAD_SRC       = 2'b01,
   parameter int                    MISS_TIMEOUT   = 256,
   parameter int                    CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1_d,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2_d,
   input  logic                      Rs1_used_d,
   input  logic                      Rs2_used_d,
   input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
   input  logic                      RegWrite_e,
   input  logic [SRC_WIDTH-1:0]      ResultSrc_e,
   input  logic                      PCSrc_e,
   input  logic                      imiss,
   input  logic                      iready,
   input  logic                      dmiss,
   input  logic                      dready,
   output logic                      en_f,
   output logic                      en_d,
   output logic                      en_m,
   output logic                      flush_n_d,
   output logic                      flush_n_e,
   output logic                      timeout_err,
   output logic [CNT_WIDTH-1:0]      stall_count
);

   localparam int              WC_W = $clog2(MISS_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WMAX = WC_W'(MISS_TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, DMISS, IMISS} state_t;

   state_t          state, state_nx;
   logic            redirect_pend, redirect_pend_nx;
   logic            i_pend, i_pend_nx;   // an icache wait is parked underneath DMISS
   logic            i_done, i_done_nx;   // iready arrived while the fetch side could not take it
   logic [WC_W-1:0] wait_cnt;

   logic lu, dm_eff, freeze, mode_run, i_rdy;

   assign lu = RegWrite_e && (ResultSrc_e == LOAD_SRC) && (Rd_e != '0) &&
               ((Rs1_used_d && (Rs1_d == Rd_e)) || (Rs2_used_d && (Rs2_d == Rd_e)));

   // A dmiss seen while DMISS is already active is ignored, so dready wins.
   assign dm_eff   = dmiss && (state != DMISS);
   assign freeze   = (state == DMISS) && !dready;
   // When dready ends a DMISS, the cycle is handled as RUN. If an icache wait
   // is parked, the cycle is handled as IMISS instead.
   assign mode_run = (state == RUN) || ((state == DMISS) && !i_pend);
   assign i_rdy    = iready || i_done;

   always_comb begin
      en_f             = 1'b1;
      en_d             = 1'b1;
      en_m             = 1'b1;
      flush_n_d        = 1'b1;
      flush_n_e        = 1'b1;
      state_nx         = state;
      redirect_pend_nx = redirect_pend;
      i_pend_nx        = i_pend;
      i_done_nx        = i_done;

      if (!rst_n) begin
         en_f      = 1'b0;
         en_d      = 1'b0;
         en_m      = 1'b0;
         flush_n_d = 1'b0;
         flush_n_e = 1'b0;
      end else if (freeze) begin
         en_f = 1'b0;
         en_d = 1'b0;
         en_m = 1'b0;
         if (i_pend && iready)
            i_done_nx = 1'b1;
      end else if (mode_run) begin
         state_nx = RUN;
         if (dm_eff) begin
            en_f      = 1'b0;
            en_d      = 1'b0;
            en_m      = 1'b0;
            state_nx  = DMISS;
            i_pend_nx = 1'b0;
         end else if (PCSrc_e) begin
            flush_n_d = 1'b0;
            flush_n_e = 1'b0;
            if (imiss) begin
               state_nx         = IMISS;
               redirect_pend_nx = 1'b1;
               i_done_nx        = 1'b0;
            end
         end else if (lu) begin
            en_f      = 1'b0;
            en_d      = 1'b0;
            flush_n_e = 1'b0;
         end else if (imiss) begin
            en_f             = 1'b0;
            flush_n_d        = 1'b0;
            state_nx         = IMISS;
            redirect_pend_nx = 1'b0;
            i_done_nx        = 1'b0;
         end
      end else begin
         // IMISS handling. Fetch is held, and decode receives bubbles.
         en_f      = 1'b0;
         flush_n_d = 1'b0;
         state_nx  = IMISS;
         i_pend_nx = 1'b0;
         if (dm_eff) begin
            en_d      = 1'b0;
            en_m      = 1'b0;
            flush_n_d = 1'b1;
            state_nx  = DMISS;
            i_pend_nx = 1'b1;
            if (iready)
               i_done_nx = 1'b1;
         end else if (PCSrc_e) begin
            flush_n_e = 1'b0;
            if (i_rdy) begin
               // The refilled word is stale. Let the PC load the target.
               en_f             = 1'b1;
               state_nx         = RUN;
               redirect_pend_nx = 1'b0;
               i_done_nx        = 1'b0;
            end else begin
               redirect_pend_nx = 1'b1;
            end
         end else if (lu) begin
            // The decode instruction must survive the stall, so the
            // fetch/decode register is held rather than cleared.
            en_d      = 1'b0;
            flush_n_e = 1'b0;
            flush_n_d = 1'b1;
            if (iready)
               i_done_nx = 1'b1;
         end else if (i_rdy) begin
            en_f             = 1'b1;
            flush_n_d        = !redirect_pend;
            state_nx         = RUN;
            redirect_pend_nx = 1'b0;
            i_done_nx        = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= RUN;
         redirect_pend <= 1'b0;
         i_pend        <= 1'b0;
         i_done        <= 1'b0;
         wait_cnt      <= '0;
         timeout_err   <= 1'b0;
         stall_count   <= '0;
      end else begin
         state         <= state_nx;
         redirect_pend <= redirect_pend_nx;
         i_pend        <= i_pend_nx;
         i_done        <= i_done_nx;
         if ((state_nx != RUN) && (state_nx != state))
            wait_cnt <= '0;
         else if ((state != RUN) && (wait_cnt != WMAX))
            wait_cnt <= wait_cnt + WC_W'(1);
         if ((state != RUN) && (wait_cnt == WMAX))
            timeout_err <= 1'b1;
         if (!en_d && (stall_count != '1))
            stall_count <= stall_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed-vector bench for hazard_ctrl. The expected values are
//   hand-computed. The output vector is packed as
//   {en_f, en_d, en_m, flush_n_d, flush_n_e}.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  Rs1_d, Rs2_d, Rd_e;
   logic        Rs1_used_d, Rs2_used_d, RegWrite_e, PCSrc_e;
   logic [1:0]  ResultSrc_e;
   logic        imiss, iready, dmiss, dready;
   logic        en_f, en_d, en_m, flush_n_d, flush_n_e, timeout_err;
   logic [31:0] stall_count;
   logic [4:0]  outs;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_sc = 0;

   localparam logic [4:0] O_RST   = 5'b00000;
   localparam logic [4:0] O_IDLE  = 5'b11111;
   localparam logic [4:0] O_LU    = 5'b00110;
   localparam logic [4:0] O_RDIR  = 5'b11100;
   localparam logic [4:0] O_FRZ   = 5'b00011;
   localparam logic [4:0] O_IMISS = 5'b01101;
   localparam logic [4:0] O_IMRD  = 5'b01100;
   localparam logic [4:0] O_STALE = 5'b11101;

   assign outs = {en_f, en_d, en_m, flush_n_d, flush_n_e};

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Rs1_d       (Rs1_d),
      .Rs2_d       (Rs2_d),
      .Rs1_used_d  (Rs1_used_d),
      .Rs2_used_d  (Rs2_used_d),
      .Rd_e        (Rd_e),
      .RegWrite_e  (RegWrite_e),
      .ResultSrc_e (ResultSrc_e),
      .PCSrc_e     (PCSrc_e),
      .imiss       (imiss),
      .iready      (iready),
      .dmiss       (dmiss),
      .dready      (dready),
      .en_f        (en_f),
      .en_d        (en_d),
      .en_m        (en_m),
      .flush_n_d   (flush_n_d),
      .flush_n_e   (flush_n_e),
      .timeout_err (timeout_err),
      .stall_count (stall_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [4:0] exp);
      #2;
      check_val(tag, 32'(outs), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Rs1_d = 5'd0; Rs2_d = 5'd0; Rd_e = 5'd0;
      Rs1_used_d = 1'b0; Rs2_used_d = 1'b0; RegWrite_e = 1'b0;
      ResultSrc_e = 2'b00; PCSrc_e = 1'b0;
      imiss = 1'b0; iready = 1'b0; dmiss = 1'b0; dready = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
      Rd_e = rd; RegWrite_e = 1'b1; ResultSrc_e = 2'b01;
      Rs1_d = rs1; Rs1_used_d = u1; Rs2_d = rs2; Rs2_used_d = u2;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      check_outs("reset_outs", O_RST);
      check_val("reset_sc", stall_count, 32'd0);
      check_val("reset_to", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      check_outs("idle", O_IDLE);

      // Load-use on Rs1, then on Rs2. Each one gives a single bubble.
      tick();
      load_use(5'd5, 5'd5, 1'b1, 5'd7, 1'b1);
      check_outs("lu_rs1", O_LU);
      tick(); idle_inputs(); exp_sc++;
      check_outs("lu_rs1_next", O_IDLE);
      check_val("lu_sc1", stall_count, 32'(exp_sc));
      load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
      check_outs("lu_rs2", O_LU);
      tick(); idle_inputs(); exp_sc++;
      check_val("lu_sc2", stall_count, 32'(exp_sc));

      // Cases that must not stall: Rd_e = 0, source unused, and a non-load result.
      load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      check_outs("lu_rd0", O_IDLE);
      load_use(5'd5, 5'd5, 1'b0, 5'd6, 1'b1);
      check_outs("lu_unused", O_IDLE);
      load_use(5'd5, 5'd5, 1'b1, 5'd6, 1'b0);
      ResultSrc_e = 2'b00;
      check_outs("alu_result", O_IDLE);
      tick(); idle_inputs();
      check_val("nostall_sc", stall_count, 32'(exp_sc));

      // A redirect beats the load-use stall.
      load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      PCSrc_e = 1'b1;
      check_outs("redir_over_lu", O_RDIR);
      tick(); idle_inputs();
      check_val("redir_sc", stall_count, 32'(exp_sc));

      // A dmiss pulse with dready 10 cycles later gives 10 frozen cycles.
      dmiss = 1'b1;
      check_outs("dmiss_c0", O_FRZ);
      tick(); dmiss = 1'b0;
      for (int i = 1; i < 10; i++) begin
         if (i == 1 || i == 9) check_outs("dmiss_wait", O_FRZ);
         tick();
      end
      dready = 1'b1;
      check_outs("dready", O_IDLE);
      tick(); idle_inputs(); exp_sc += 10;
      check_val("dmiss_sc", stall_count, 32'(exp_sc));
      check_outs("after_dmiss", O_IDLE);

      // dmiss and dready together while in DMISS: dready wins.
      dmiss = 1'b1;
      tick();
      dready = 1'b1;
      check_outs("dmiss_dready", O_IDLE);
      tick(); idle_inputs(); exp_sc += 1;
      check_outs("dmiss_dready_run", O_IDLE);

      // imiss, then a redirect at wait cycle 3, then iready at cycle 6.
      imiss = 1'b1;
      check_outs("imiss_c0", O_IMISS);
      tick(); imiss = 1'b0;
      check_outs("imiss_c1", O_IMISS);
      tick(); tick();
      PCSrc_e = 1'b1;
      check_outs("imiss_redir", O_IMRD);
      tick(); PCSrc_e = 1'b0;
      check_outs("imiss_c4", O_IMISS);
      tick(); tick();
      iready = 1'b1;
      check_outs("iready_stale", O_STALE);
      tick(); iready = 1'b0;
      check_outs("imiss_run", O_IDLE);
      check_val("imiss_sc", stall_count, 32'(exp_sc));

      // A plain imiss finished by iready.
      imiss = 1'b1;
      tick(); imiss = 1'b0;
      iready = 1'b1;
      check_outs("iready_plain", O_IDLE);
      tick(); iready = 1'b0;

      // imiss, then a dmiss on top of it, with iready arriving during DMISS.
      imiss = 1'b1;
      tick(); imiss = 1'b0;
      dmiss = 1'b1;
      check_outs("im_dmiss", O_FRZ);
      tick(); dmiss = 1'b0;
      iready = 1'b1;
      check_outs("im_dmiss_iready", O_FRZ);
      tick(); iready = 1'b0;
      dready = 1'b1;
      check_outs("im_dready", O_IDLE);
      tick(); dready = 1'b0; exp_sc += 2;
      check_outs("im_dready_run", O_IDLE);
      check_val("im_dmiss_sc", stall_count, 32'(exp_sc));

      // Timeout: dmiss with no dready.
      check_val("to_pre", 32'(timeout_err), 32'd0);
      dmiss = 1'b1;
      tick(); dmiss = 1'b0;
      for (int i = 0; i < 255; i++) tick();
      check_val("to_early", 32'(timeout_err), 32'd0);
      tick(); exp_sc += 257;
      check_val("to_set", 32'(timeout_err), 32'd1);
      check_val("to_sc", stall_count, 32'(exp_sc));
      dready = 1'b1;
      tick(); dready = 1'b0;
      check_val("to_sticky", 32'(timeout_err), 32'd1);
      rst_n = 1'b0;
      check_outs("rst_outs", O_RST);
      tick();
      check_val("to_cleared", 32'(timeout_err), 32'd0);
      check_val("sc_cleared", stall_count, 32'd0);

      // A reset in the middle of a miss returns to RUN.
      rst_n = 1'b1;
      imiss = 1'b1;
      tick(); imiss = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_outs("rst_mid_miss", O_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
